hyper_phy_sched: RTL and testbench
==================================

HYPER_PHY_SCHED -- requirements
Module: hyper_phy_sched

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32, meaning the transaction address width.
REQ-002 The block SHALL have parameter LenWidth, default 8, meaning the burst length field width.
REQ-003 The block SHALL have parameter MaxOutstanding, default 4, meaning the maximum number of in-flight transactions per PHY (range 1..15).
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-005 The block SHALL have these ports:
- cfg_valid_i  in  1  single-cycle configuration write strobe.
- cfg_both_i  in  1  1 = use both PHYs, 0 = single PHY.
- cfg_which_i  in  1  PHY index used when cfg_both_i=0.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_addr_i  in  AddrWidth  request address.
- req_len_i  in  LenWidth  request length.
- req_write_i  in  1  1 = write, 0 = read.
- phy_valid_o  out  2  per-PHY command valid, one-hot or zero.
- phy_ready_i  in  2  per-PHY command ready.
- phy_addr_o  out  AddrWidth  command address, shared by both PHYs.
- phy_len_o  out  LenWidth  command length, shared.
- phy_write_o  out  1  command direction, shared.
- phy_done_i  in  2  per-PHY completion pulse.
- busy_o  out  1  high when any command is held or outstanding.
- cfg_both_o  out  1  applied mode.
- cfg_which_o  out  1  applied PHY index.
- err_o  out  1  sticky completion-underflow error.

Function
REQ-006 The block SHALL implement FSM states RUN, DRAIN and APPLY.
REQ-007 Transitions SHALL be:
- RUN -> DRAIN on cfg_valid_i.
- DRAIN -> APPLY when the output register is empty and both outstanding counters are 0.
- APPLY -> RUN after exactly one cycle, in which the pending configuration is copied to cfg_both_o and cfg_which_o.
REQ-008 cfg_valid_i in DRAIN SHALL overwrite the pending configuration. cfg_valid_i in APPLY SHALL capture a new pending value and go to DRAIN, not RUN.
REQ-009 The block SHALL hold a one-entry output register (addr, len, write, target, valid). phy_valid_o[target] SHALL be high when the register is valid, and all phy_* outputs SHALL stay stable until phy_ready_i[target] is high.
REQ-010 credit[p] SHALL equal MaxOutstanding - outstanding[p] - (1 if the output register is valid and targets p, else 0).
REQ-011 Target selection:
- Single mode: target = cfg_which_o.
- Both mode: target = rr. If credit[rr]=0 and credit[!rr]>0, target = !rr.
REQ-012 req_ready_o SHALL be 1 only when the state is RUN, the output register is empty, and credit[target]>0; it SHALL be combinational from state and registers only, never from req_valid_i.
REQ-013 On a req handshake the request SHALL be latched, phy_valid_o SHALL assert in the next cycle, and in both mode rr SHALL become !target.
REQ-014 Sustained throughput SHALL be at most one accepted request per two cycles; there is no bypass in the handshake cycle.
REQ-015 outstanding[p] SHALL increment on phy_valid_o[p]&phy_ready_i[p] and decrement on phy_done_i[p]; when both occur in the same cycle it SHALL stay unchanged.
REQ-016 phy_done_i[p] while outstanding[p]=0 SHALL be ignored and SHALL set err_o, which stays set until reset.
REQ-017 phy_done_i on both PHYs in one cycle SHALL decrement both counters.
REQ-018 busy_o SHALL equal output-register valid OR outstanding[0]!=0 OR outstanding[1]!=0.
REQ-019 Counters SHALL be 4 bits wide and SHALL never wrap; REQ-012 guarantees no overflow.

Reset
REQ-020 rst_i SHALL be sampled on the rising edge of clk_i. While it is high, the block SHALL set state RUN, cfg_both_o=1, cfg_which_o=0, rr=0, the output register empty, both counters 0, err_o=0, and discard any pending configuration.
REQ-021 After reset: req_ready_o=1, phy_valid_o=0, busy_o=0, phy_addr_o=0, phy_len_o=0, phy_write_o=0.
REQ-022 Reset asserted mid-transaction or mid-DRAIN SHALL drop all in-flight state without emitting further phy_valid_o.

Verification
REQ-023 Scenario: both mode, phy_ready_i=2'b11, four requests at addr 0x8000_0000..0x8000_0018 -> targets 0,1,0,1; each phy_valid_o appears one cycle after its accept.
REQ-024 Scenario: both mode, phy_done_i never pulsed, MaxOutstanding=4 -> eight commands issued (4 per PHY), then req_ready_o=0 until one phy_done_i pulse restores exactly one credit.
REQ-025 Scenario: cfg_valid_i with cfg_both_i=0 and cfg_which_i=1 while 3 commands are outstanding -> req_ready_o=0 until the third done; one APPLY cycle; then all following commands target PHY 1 only.
REQ-026 Scenario: phy_ready_i[0]=0 for 10 cycles with a held command -> phy_addr_o, phy_len_o and phy_write_o stay stable and req_ready_o=0 throughout.
REQ-027 Scenario: phy_done_i[1] with outstanding[1]=0 -> err_o=1 sticky and counters unchanged; also a simultaneous handshake plus done on PHY 0 -> outstanding[0] unchanged.
REQ-028 Scenario: rst_i asserted during DRAIN with a held command -> next cycle phy_valid_o=0, busy_o=0, cfg_both_o=1.

Source files
------------

// File: rtl/hyper_phy_sched.sv
// Command scheduler that spreads requests over one or two PHYs with per-PHY credit tracking
// and a drain-then-apply handshake for changing the PHY mode safely.
module hyper_phy_sched #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned LenWidth       = 8,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  input  logic                 cfg_both_i,
  input  logic                 cfg_which_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]  req_len_i,
  input  logic                 req_write_i,
  output logic [1:0]           phy_valid_o,
  input  logic [1:0]           phy_ready_i,
  output logic [AddrWidth-1:0] phy_addr_o,
  output logic [LenWidth-1:0]  phy_len_o,
  output logic                 phy_write_o,
  input  logic [1:0]           phy_done_i,
  output logic                 busy_o,
  output logic                 cfg_both_o,
  output logic                 cfg_which_o,
  output logic                 err_o
);

  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StApply = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  pend_both_q, pend_both_d;
  logic                  pend_which_q, pend_which_d;
  logic                  cfg_both_q, cfg_both_d;
  logic                  cfg_which_q, cfg_which_d;
  logic                  rr_q, rr_d;
  logic                  ov_q, ov_d;
  logic [AddrWidth-1:0]  oaddr_q, oaddr_d;
  logic [LenWidth-1:0]   olen_q, olen_d;
  logic                  owr_q, owr_d;
  logic                  otgt_q, otgt_d;
  logic [CntWidth-1:0]   outst_q [2];
  logic [CntWidth-1:0]   outst_d [2];
  logic                  err_q, err_d;

  logic [CntWidth-1:0]   credit [2];
  logic                  tgt;
  logic                  req_hs;
  logic                  phy_hs;

  // Credits count the held command against its target so the counter can never overflow.
  always_comb begin
    credit[0] = CntWidth'(MaxOutstanding) - outst_q[0] - CntWidth'(ov_q && !otgt_q);
    credit[1] = CntWidth'(MaxOutstanding) - outst_q[1] - CntWidth'(ov_q && otgt_q);
    if (!cfg_both_q) begin
      tgt = cfg_which_q;
    end else if ((credit[rr_q] == '0) && (credit[!rr_q] != '0)) begin
      tgt = !rr_q;
    end else begin
      tgt = rr_q;
    end
  end

  assign req_ready_o = (state_q == StRun) && !ov_q && (credit[tgt] != '0);
  assign req_hs      = req_valid_i && req_ready_o;
  assign phy_hs      = ov_q && phy_ready_i[otgt_q];

  always_comb begin
    state_d      = state_q;
    pend_both_d  = pend_both_q;
    pend_which_d = pend_which_q;
    cfg_both_d   = cfg_both_q;
    cfg_which_d  = cfg_which_q;
    rr_d         = rr_q;
    ov_d         = ov_q;
    oaddr_d      = oaddr_q;
    olen_d       = olen_q;
    owr_d        = owr_q;
    otgt_d       = otgt_q;
    outst_d[0]   = outst_q[0];
    outst_d[1]   = outst_q[1];
    err_d        = err_q;

    unique case (state_q)
      StRun: begin
        if (cfg_valid_i) begin
          pend_both_d  = cfg_both_i;
          pend_which_d = cfg_which_i;
          state_d      = StDrain;
        end
      end
      StDrain: begin
        if (cfg_valid_i) begin
          pend_both_d  = cfg_both_i;
          pend_which_d = cfg_which_i;
        end
        if (!ov_q && (outst_q[0] == '0) && (outst_q[1] == '0)) begin
          state_d = StApply;
        end
      end
      StApply: begin
        cfg_both_d  = pend_both_q;
        cfg_which_d = pend_which_q;
        state_d     = StRun;
        if (cfg_valid_i) begin
          pend_both_d  = cfg_both_i;
          pend_which_d = cfg_which_i;
          state_d      = StDrain;
        end
      end
      default: state_d = StRun;
    endcase

    if (phy_hs) begin
      ov_d = 1'b0;
    end
    if (req_hs) begin
      ov_d    = 1'b1;
      oaddr_d = req_addr_i;
      olen_d  = req_len_i;
      owr_d   = req_write_i;
      otgt_d  = tgt;
      if (cfg_both_q) begin
        rr_d = !tgt;
      end
    end

    // A done on an idle PHY is dropped and flagged; issue and done together cancel out.
    for (int p = 0; p < 2; p++) begin
      logic inc;
      logic dec;
      inc = phy_hs && (otgt_q == 1'(p));
      dec = phy_done_i[p];
      if (dec && (outst_q[p] == '0)) begin
        err_d = 1'b1;
        dec   = 1'b0;
      end
      if (inc && !dec) begin
        outst_d[p] = outst_q[p] + CntWidth'(1);
      end else if (dec && !inc) begin
        outst_d[p] = outst_q[p] - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StRun;
      pend_both_q  <= 1'b1;
      pend_which_q <= 1'b0;
      cfg_both_q   <= 1'b1;
      cfg_which_q  <= 1'b0;
      rr_q         <= 1'b0;
      ov_q         <= 1'b0;
      oaddr_q      <= '0;
      olen_q       <= '0;
      owr_q        <= 1'b0;
      otgt_q       <= 1'b0;
      outst_q[0]   <= '0;
      outst_q[1]   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_both_q  <= pend_both_d;
      pend_which_q <= pend_which_d;
      cfg_both_q   <= cfg_both_d;
      cfg_which_q  <= cfg_which_d;
      rr_q         <= rr_d;
      ov_q         <= ov_d;
      oaddr_q      <= oaddr_d;
      olen_q       <= olen_d;
      owr_q        <= owr_d;
      otgt_q       <= otgt_d;
      outst_q[0]   <= outst_d[0];
      outst_q[1]   <= outst_d[1];
      err_q        <= err_d;
    end
  end

  assign phy_valid_o = {ov_q && otgt_q, ov_q && !otgt_q};
  assign phy_addr_o  = oaddr_q;
  assign phy_len_o   = olen_q;
  assign phy_write_o = owr_q;
  assign busy_o      = ov_q || (outst_q[0] != '0) || (outst_q[1] != '0);
  assign cfg_both_o  = cfg_both_q;
  assign cfg_which_o = cfg_which_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hyper_phy_sched.sv
// Scoreboard bench for hyper_phy_sched: expected PHY commands are queued at accept time and
// popped by an independent monitor whenever a PHY handshake is presented.
module tb_hyper_phy_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_both_i = 1'b0;
  logic        cfg_which_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [7:0]  req_len_i = '0;
  logic        req_write_i = 1'b0;
  logic [1:0]  phy_valid_o;
  logic [1:0]  phy_ready_i = 2'b00;
  logic [31:0] phy_addr_o;
  logic [7:0]  phy_len_o;
  logic        phy_write_o;
  logic [1:0]  phy_done_i = 2'b00;
  logic        busy_o;
  logic        cfg_both_o;
  logic        cfg_which_o;
  logic        err_o;

  hyper_phy_sched dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_both_i  (cfg_both_i),
    .cfg_which_i (cfg_which_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_len_i   (req_len_i),
    .req_write_i (req_write_i),
    .phy_valid_o (phy_valid_o),
    .phy_ready_i (phy_ready_i),
    .phy_addr_o  (phy_addr_o),
    .phy_len_o   (phy_len_o),
    .phy_write_o (phy_write_o),
    .phy_done_i  (phy_done_i),
    .busy_o      (busy_o),
    .cfg_both_o  (cfg_both_o),
    .cfg_which_o (cfg_which_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        wr;
    logic        tgt;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request and expect it on PHY t one cycle after acceptance.
  task automatic send(input logic [31:0] a, input logic [7:0] l, input logic w, input logic t);
    cmd_t c;
    bit   ok;
    ok = 1'b0;
    step();
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_len_i   = l;
    req_write_i = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: req_ready_o stayed 0 for addr 0x%0h", a);
      req_valid_i = 1'b0;
    end else begin
      @(posedge clk_i);
      c.addr = a;
      c.len  = l;
      c.wr   = w;
      c.tgt  = t;
      exp_q.push_back(c);
      #1 req_valid_i = 1'b0;
      @(negedge clk_i);
      check("valid_after_accept", 64'(phy_valid_o), 64'(t ? 2'b10 : 2'b01));
    end
  endtask

  task automatic pulse_done(input logic [1:0] d, input int n);
    step();
    phy_done_i = d;
    repeat (n) step();
    phy_done_i = 2'b00;
  endtask

  // Monitor: every presented PHY handshake must match the oldest expected command.
  always @(negedge clk_i) begin
    cmd_t e;
    if (!rst_i && ((phy_valid_o & phy_ready_i) != 2'b00)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_cmd: got addr 0x%0h valid %b, expected none", phy_addr_o, phy_valid_o);
      end else begin
        e = exp_q.pop_front();
        check("cmd_addr", 64'(phy_addr_o), 64'(e.addr));
        check("cmd_len", 64'(phy_len_o), 64'(e.len));
        check("cmd_write", 64'(phy_write_o), 64'(e.wr));
        check("cmd_target", 64'(phy_valid_o), 64'(e.tgt ? 2'b10 : 2'b01));
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk_i);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", 64'(req_ready_o), 64'(1));
    check("rst_valid", 64'(phy_valid_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_addr", 64'(phy_addr_o), 64'(0));
    check("rst_len", 64'(phy_len_o), 64'(0));
    check("rst_write", 64'(phy_write_o), 64'(0));
    check("rst_cfg_both", 64'(cfg_both_o), 64'(1));
    check("rst_cfg_which", 64'(cfg_which_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));

    // Round-robin over both PHYs with ready PHYs.
    step();
    phy_ready_i = 2'b11;
    send(32'h8000_0000, 8'h04, 1'b0, 1'b0);
    send(32'h8000_0008, 8'h08, 1'b1, 1'b1);
    send(32'h8000_0010, 8'h10, 1'b0, 1'b0);
    send(32'h8000_0018, 8'h20, 1'b1, 1'b1);
    @(negedge clk_i);
    check("rr_busy", 64'(busy_o), 64'(1));
    pulse_done(2'b11, 2);
    @(negedge clk_i);
    check("rr_drained_busy", 64'(busy_o), 64'(0));

    // Credit exhaustion: four per PHY, then one done frees exactly one slot.
    for (int i = 0; i < 8; i++) begin
      send(32'h9000_0000 + 32'(i * 16), 8'(i + 1), 1'b0, 1'(i % 2));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("credit_full_ready", 64'(req_ready_o), 64'(0));
    end
    pulse_done(2'b01, 1);
    @(negedge clk_i);
    check("credit_one_back", 64'(req_ready_o), 64'(1));
    send(32'h9000_0100, 8'h55, 1'b1, 1'b0);
    @(negedge clk_i);
    check("credit_used_again", 64'(req_ready_o), 64'(0));
    pulse_done(2'b11, 4);
    @(negedge clk_i);
    check("credit_drained_busy", 64'(busy_o), 64'(0));

    // Done on an idle PHY sets sticky err and leaves counters alone.
    pulse_done(2'b10, 1);
    @(negedge clk_i);
    check("underflow_err", 64'(err_o), 64'(1));
    check("underflow_busy", 64'(busy_o), 64'(0));
    check("underflow_ready", 64'(req_ready_o), 64'(1));

    // Back-pressure: a command held on PHY 0 must not move.
    step();
    phy_ready_i = 2'b10;
    send(32'h2000_0000, 8'h10, 1'b0, 1'b1);
    send(32'h1234_5678, 8'h3c, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("hold_addr", 64'(phy_addr_o), 64'(32'h1234_5678));
      check("hold_len", 64'(phy_len_o), 64'(8'h3c));
      check("hold_write", 64'(phy_write_o), 64'(1));
      check("hold_ready", 64'(req_ready_o), 64'(0));
      check("hold_valid", 64'(phy_valid_o), 64'(2'b01));
      if (i == 3) pulse_done(2'b10, 1);
    end
    step();
    phy_ready_i = 2'b01;
    step();
    phy_ready_i = 2'b00;
    send(32'h3000_0000, 8'h01, 1'b0, 1'b1);
    step();
    phy_ready_i = 2'b10;
    step();
    phy_ready_i = 2'b00;
    send(32'h3000_0040, 8'h02, 1'b1, 1'b0);
    // Issue and done on PHY 0 in the same cycle.
    step();
    phy_ready_i = 2'b01;
    phy_done_i  = 2'b01;
    step();
    phy_ready_i = 2'b00;
    phy_done_i  = 2'b00;
    @(negedge clk_i);
    check("simul_busy", 64'(busy_o), 64'(1));
    pulse_done(2'b10, 1);
    @(negedge clk_i);
    check("simul_phy0_kept", 64'(busy_o), 64'(1));
    pulse_done(2'b01, 1);
    @(negedge clk_i);
    check("simul_phy0_one", 64'(busy_o), 64'(0));
    check("err_sticky", 64'(err_o), 64'(1));

    // Mode switch to PHY 1 only while three commands are outstanding.
    step();
    phy_ready_i = 2'b11;
    send(32'h4000_0000, 8'h11, 1'b0, 1'b1);
    send(32'h4000_0008, 8'h12, 1'b0, 1'b0);
    send(32'h4000_0010, 8'h13, 1'b1, 1'b1);
    step();
    cfg_valid_i = 1'b1;
    cfg_both_i  = 1'b1;
    cfg_which_i = 1'b0;
    step();
    cfg_both_i  = 1'b0;
    cfg_which_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
    @(negedge clk_i);
    check("drain_ready0", 64'(req_ready_o), 64'(0));
    step();
    phy_done_i = 2'b10;
    @(negedge clk_i);
    check("drain_ready1", 64'(req_ready_o), 64'(0));
    step();
    phy_done_i = 2'b01;
    @(negedge clk_i);
    check("drain_ready2", 64'(req_ready_o), 64'(0));
    step();
    phy_done_i = 2'b10;
    step();
    phy_done_i = 2'b00;
    @(negedge clk_i);
    check("drain_last_ready", 64'(req_ready_o), 64'(0));
    check("drain_last_both", 64'(cfg_both_o), 64'(1));
    @(negedge clk_i);
    check("apply_ready", 64'(req_ready_o), 64'(0));
    check("apply_both", 64'(cfg_both_o), 64'(1));
    @(negedge clk_i);
    check("run_ready", 64'(req_ready_o), 64'(1));
    check("run_both", 64'(cfg_both_o), 64'(0));
    check("run_which", 64'(cfg_which_o), 64'(1));
    send(32'h5000_0000, 8'h21, 1'b0, 1'b1);
    send(32'h5000_0008, 8'h22, 1'b1, 1'b1);
    send(32'h5000_0010, 8'h23, 1'b0, 1'b1);
    pulse_done(2'b10, 3);
    @(negedge clk_i);
    check("single_busy", 64'(busy_o), 64'(0));
    check("all_cmds_seen", 64'(exp_q.size()), 64'(0));

    // Reset during DRAIN with a held command drops everything.
    step();
    phy_ready_i = 2'b00;
    send(32'h6000_0000, 8'h07, 1'b1, 1'b1);
    step();
    cfg_valid_i = 1'b1;
    cfg_both_i  = 1'b0;
    cfg_which_i = 1'b0;
    step();
    cfg_valid_i = 1'b0;
    @(negedge clk_i);
    check("pre_rst_ready", 64'(req_ready_o), 64'(0));
    check("pre_rst_valid", 64'(phy_valid_o), 64'(2'b10));
    step();
    rst_i = 1'b1;
    exp_q.delete();
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_valid", 64'(phy_valid_o), 64'(0));
    check("mid_rst_busy", 64'(busy_o), 64'(0));
    check("mid_rst_both", 64'(cfg_both_o), 64'(1));
    check("mid_rst_which", 64'(cfg_which_o), 64'(0));
    check("mid_rst_err", 64'(err_o), 64'(0));
    check("mid_rst_ready", 64'(req_ready_o), 64'(1));
    check("mid_rst_addr", 64'(phy_addr_o), 64'(0));
    step();
    phy_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_rst_quiet", 64'(phy_valid_o), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
